// File: rtl/echo_line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// echo_line_buffer_pkg
// Shared definitions for the echo line buffer: datapath widths, write/read FSM
// state encodings and the helper that maps {bank, address} to a flat RAM
// address.
// -----------------------------------------------------------------------------
package echo_line_buffer_pkg;

    localparam int AW     = 12;       // PDC index / line address width
    localparam int SMP_W  = 8;        // ADC sample width
    localparam int DC_W   = 8;        // decimation counter width (DECIM <= 255)
    localparam int FLAT_W = AW + 1;   // {bank, addr} flattened

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_CAP    = 2'd1,
        WR_COMMIT = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_FREE = 2'd0,
        RD_PEND = 2'd1,
        RD_ACT  = 2'd2
    } rd_state_e;

    // Bank 1 sits directly after bank 0, so a line of 'depth' samples packs
    // both banks into 2*depth consecutive words.
    function automatic logic [FLAT_W-1:0] bank_addr(
        input logic          bank,
        input logic [AW-1:0] addr,
        input int            depth
    );
        logic [FLAT_W-1:0] base;
        base = bank ? FLAT_W'(depth) : '0;
        return base + {1'b0, addr};
    endfunction

endpackage

// File: rtl/echo_line_ram.sv
// -----------------------------------------------------------------------------
// echo_line_ram
// Simple dual-port RAM holding both ping-pong banks. One synchronous write
// port and one synchronous read port on the same clock; no reset on the array
// or the read register so it maps onto block RAM.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address (flat {bank,addr})
//   i_wdata  in   write data
//   i_raddr  in   read address (flat {bank,addr})
//   o_rdata  out  read data, one clock after i_raddr
// -----------------------------------------------------------------------------
module echo_line_ram
    import echo_line_buffer_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [RA_W-1:0]  i_waddr,
    input  logic [SMP_W-1:0] i_wdata,
    input  logic [RA_W-1:0]  i_raddr,
    output logic [SMP_W-1:0] o_rdata
);

    logic [SMP_W-1:0] r_mem [2**RA_W];
    logic [SMP_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_line_buffer.sv
// -----------------------------------------------------------------------------
// echo_line_buffer
// Captures one echo line of ADC samples after each ping trigger into one bank
// of a ping-pong buffer while the PDC stage reads the other bank by index.
// A finished line is handed over with a one-cycle output_ON pulse; if PDC is
// still holding the previous line the new one is dropped and overrun latches.
// Ports:
//   clk          in   clock, rising edge
//   res          in   synchronous reset, active high
//   start        in   ping trigger; starts or restarts a line capture
//   smp_valid    in   sample strobe
//   smp_data     in   ADC sample
//   dataReadReq  in   high while PDC reads a line
//   index        in   PDC read address
//   data         out  sample at index in the read bank (1-edge latency)
//   output_ON    out  one-cycle pulse per committed line
//   busy         out  high while capturing
//   overrun      out  sticky, a line was dropped
// -----------------------------------------------------------------------------
module echo_line_buffer
    import echo_line_buffer_pkg::*;
#(
    parameter int H_BYTES = 4,
    parameter int DECIM   = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [SMP_W-1:0] smp_data,
    input  logic             dataReadReq,
    input  logic [AW-1:0]    index,
    output logic [SMP_W-1:0] data,
    output logic             output_ON,
    output logic             busy,
    output logic             overrun
);

    localparam int              RA_W     = $clog2(2 * H_BYTES);
    localparam logic [AW-1:0]   LAST_ADR = AW'(H_BYTES - 1);
    localparam logic [AW-1:0]   LINE_LEN = AW'(H_BYTES);
    localparam logic [DC_W-1:0] DEC_LAST = DC_W'(DECIM - 1);

    wr_state_e        r_wr_state;
    rd_state_e        r_rd_state;
    logic             r_wr_bank;
    logic [AW-1:0]    r_wr_addr;
    logic [DC_W-1:0]  r_decim_cnt;
    logic             r_req_d;
    logic             r_output_on;
    logic             r_overrun;
    logic             r_data_ok;

    logic             w_accept;
    logic             w_req_rise;
    logic             w_req_fall;
    logic             w_rd_free;
    logic             w_idx_ok;
    logic [AW-1:0]    w_rd_idx;
    logic [RA_W-1:0]  w_waddr;
    logic [RA_W-1:0]  w_raddr;
    logic [SMP_W-1:0] w_ram_q;

    assign w_req_rise = dataReadReq & ~r_req_d;
    assign w_req_fall = ~dataReadReq & r_req_d;

    // A release happening in the commit cycle counts as already done, so the
    // commit is not turned into an overrun by one cycle of skew.
    assign w_rd_free = (r_rd_state == RD_FREE) ||
                       ((r_rd_state == RD_ACT) && w_req_fall);

    // start in CAP restarts the line and suppresses the write of that cycle.
    assign w_accept = (r_wr_state == WR_CAP) && !start && smp_valid &&
                      (r_decim_cnt == DEC_LAST);

    // Out-of-range indices read a harmless in-range word; the output is
    // forced to zero instead.
    assign w_idx_ok = (index < LINE_LEN);
    assign w_rd_idx = w_idx_ok ? index : '0;

    // The read bank is always the opposite of the write bank, so the bank
    // being filled is never visible to PDC.
    assign w_waddr = RA_W'(bank_addr(r_wr_bank,  r_wr_addr, H_BYTES));
    assign w_raddr = RA_W'(bank_addr(~r_wr_bank, w_rd_idx,  H_BYTES));

    echo_line_ram #(
        .RA_W (RA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_waddr),
        .i_wdata (smp_data),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_wr_state  <= WR_IDLE;
            r_rd_state  <= RD_FREE;
            r_wr_bank   <= 1'b0;
            r_wr_addr   <= '0;
            r_decim_cnt <= '0;
            r_req_d     <= 1'b0;
            r_output_on <= 1'b0;
            r_overrun   <= 1'b0;
            r_data_ok   <= 1'b0;
        end else begin
            r_req_d     <= dataReadReq;
            r_output_on <= 1'b0;
            r_data_ok   <= w_idx_ok;

            // Read FSM: edges outside PEND/ACT are ignored.
            case (r_rd_state)
                RD_PEND: if (w_req_rise) r_rd_state <= RD_ACT;
                RD_ACT:  if (w_req_fall) r_rd_state <= RD_FREE;
                default: r_rd_state <= RD_FREE;
            endcase

            // Write FSM. The commit branch is last so its RD_PEND overrides
            // a release of the read FSM in the same cycle.
            case (r_wr_state)
                WR_IDLE: begin
                    if (start) begin
                        r_wr_state  <= WR_CAP;
                        r_wr_addr   <= '0;
                        r_decim_cnt <= '0;
                    end
                end
                WR_CAP: begin
                    if (start) begin
                        r_wr_addr   <= '0;
                        r_decim_cnt <= '0;
                    end else if (smp_valid) begin
                        if (w_accept) begin
                            r_decim_cnt <= '0;
                            r_wr_addr   <= r_wr_addr + AW'(1);
                            if (r_wr_addr == LAST_ADR) begin
                                r_wr_state <= WR_COMMIT;
                            end
                        end else begin
                            r_decim_cnt <= r_decim_cnt + DC_W'(1);
                        end
                    end
                end
                WR_COMMIT: begin
                    if (w_rd_free) begin
                        r_wr_bank   <= ~r_wr_bank;
                        r_output_on <= 1'b1;
                        r_rd_state  <= RD_PEND;
                    end else begin
                        r_overrun   <= 1'b1;
                    end
                    r_wr_state <= WR_IDLE;
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    assign data      = r_data_ok ? w_ram_q : '0;
    assign output_ON = r_output_on;
    assign busy      = (r_wr_state == WR_CAP);
    assign overrun   = r_overrun;

endmodule
